rs232_rx_fifo: RTL
==================

Name: rs232_rx_fifo

Overview:
- Receive buffer directly downstream of the RS232 byte receiver.
- Consumes the receiver's rdy/data pair, acknowledges each byte with a one-cycle done pulse, and stores the byte in a DEPTH-entry FIFO.
- Presents the FIFO to the CPU I/O decoder with show-ahead read data, a pop strobe, fill count and sticky overrun flag, so software can tolerate latency of several byte times at 115200 bps.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
AW, 4, pointer width, log2(DEPTH)

Ports:
clk  in  1  system clock (25 MHz)
rst  in  1  reset; asynchronous, active-high
rx_rdy  in  1  receiver "byte available" (receiver rdy)
rx_data  in  8  receiver byte (receiver data)
rx_done  out  1  one-cycle acknowledge to receiver (receiver done)
rd  in  1  CPU pop strobe, one cycle per byte
rd_data  out  8  head entry (show-ahead); 8'h00 when empty
empty  out  1  FIFO empty
full  out  1  FIFO holds DEPTH entries
count  out  AW+1  number of stored entries, 0..DEPTH
ovr  out  1  sticky overrun; a byte was dropped
ovr_clr  in  1  clears ovr

Behaviour:
- Reset (async, rst=1):
  - wptr=rptr=0, count=0, empty=1, full=0, ovr=0, rx_done=0.
  - Capture FSM to IDLE. Memory contents are not reset.
  - Reset mid-transfer discards all stored bytes and any pending acknowledge.
- Capture FSM, 2 states:
  - IDLE: if rx_rdy=1, at the clock edge rx_data is written (or dropped, see below), rx_done is registered high and the FSM goes to WAIT.
  - WAIT: rx_done=0. Stay while rx_rdy=1; go to IDLE when rx_rdy=0.
  - This prevents a double write during the cycle in which the receiver is still clearing rdy.
- Ack timing:
  - rx_done is high exactly one cycle, in the cycle after IDLE sees rx_rdy.
  - The receiver drops rdy one cycle later.
  - Minimum 3 cycles per byte, far below the ≥217-cycle bit time.
- Write acceptance:
  - The byte is written at mem[wptr] and wptr increments (mod DEPTH) when count<DEPTH, or when count==DEPTH and a valid pop occurs in the same cycle.
  - Otherwise the byte is dropped, ovr is set to 1 and the receiver is still acknowledged.
  - The receiver is never stalled.
- Pop:
  - rd=1 with count>0 increments rptr (mod DEPTH).
  - rd with count==0 is ignored: no pointer change, no flag change.
- Count:
  - +1 on write only, −1 on pop only, unchanged on simultaneous write and pop.
  - empty = (count==0); full = (count==DEPTH).
  - Pointers are AW bits and wrap silently; count is the sole full/empty discriminator.
- rd_data:
  - Combinational read of mem[rptr], gated to 0 when empty.
  - The new head is visible the cycle after a pop.
  - A byte written into an empty FIFO is visible the cycle after the write edge.
- ovr:
  - Set has priority over ovr_clr when both occur in the same cycle.
  - Otherwise ovr_clr clears it; it is otherwise held.
- No combinational path from rx_rdy to rx_done or from rd to rd_data.

Decomposition:
- Shared package (rs232_pkg): capture state encoding (ST_IDLE=0, ST_WAIT=1) and default DEPTH constant. The package is shared with the transmitter buffer.
- One natural sub-module: rs232_fifo_mem, a DEPTH×8 register file with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). Pointer/count/flag logic and the FSM live in the top.

Test Plan:
- Single byte: after reset, drive rx_rdy=1 with rx_data=8'hA5, drop rx_rdy one cycle after rx_done -> rx_done high exactly 1 cycle, count=1, empty=0, rd_data=8'hA5; pulse rd -> count=0, empty=1, rd_data=8'h00.
- Held rdy: keep rx_rdy=1 for 5 cycles after rx_done -> exactly one write, count=1, one rx_done pulse.
- Fill/overflow: write 8'h00..8'h10 (17 bytes) with DEPTH=16 -> full=1 after 16, 17th dropped, ovr=1, 17 rx_done pulses; 16 pops return 8'h00..8'h0F in order; ovr_clr -> ovr=0.
- Wrap-around: push 10, pop 10, push 12 (8'h20..8'h2B), pop all -> data in order across the pointer wrap, count returns to 0.
- Simultaneous: with count==16, write 8'h55 while rd=1 -> no overrun, count stays 16, 8'h55 emerges last; with count==3, write+rd -> count 3. rd on empty -> no change.
- Reset mid-operation: assert rst with count=5 and rx_done pending -> immediately count=0, empty=1, rx_done=0, ovr=0; after release the next byte is accepted normally.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: capture FSM encoding and default buffer depth.
// Used by both the receive and transmit buffers.
package rs232_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/rs232_rx_fifo_if.sv
// Bundle between the receive buffer, the RS232 byte receiver and the CPU I/O decoder.
// The slave modport is the buffer; the master modport is the receiver and CPU side.
interface rs232_rx_fifo_if
    import rs232_pkg::*;
#(
    parameter int AW = $clog2(DEFAULT_DEPTH)
);
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          rd;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          ovr;
    logic          ovr_clr;

    modport slave (
        input  rx_rdy, rx_data, rd, ovr_clr,
        output rx_done, rd_data, empty, full, count, ovr
    );

    modport master (
        output rx_rdy, rx_data, rd, ovr_clr,
        input  rx_done, rd_data, empty, full, count, ovr
    );
endinterface

// File: rtl/rs232_fifo_mem.sv
// DEPTH x 8 register file: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module rs232_fifo_mem
    import rs232_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    // Store one byte per accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rs232_rx_fifo.sv
// RS232 receive buffer: acknowledges receiver bytes and queues them in a FIFO
// read by the CPU with show-ahead data, fill count and sticky overrun.
module rs232_rx_fifo
    import rs232_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    rs232_rx_fifo_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [0:0]    state;
    logic          done_q;
    logic          ovr_q;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic [7:0]    head;
    logic          capture;
    logic          pop;
    logic          wr;
    logic          drop;

    // Capture happens once per rdy assertion; a full FIFO only accepts
    // when a pop frees a slot in the same cycle
    assign capture = (state == ST_IDLE) && bus.rx_rdy;
    assign pop     = bus.rd && (cnt != '0);
    assign wr      = capture && ((cnt != FULL_CNT) || pop);
    assign drop    = capture && !wr;

    // Capture FSM and registered one-cycle acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= capture;
            unique case (state)
                ST_IDLE: if (bus.rx_rdy)  state <= ST_WAIT;
                ST_WAIT: if (!bus.rx_rdy) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pointers wrap silently; the count alone tells full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    // Fill count: net change of write and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !wr) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Sticky overrun; a drop wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (drop) begin
            ovr_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    rs232_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr),
        .waddr (wptr),
        .wdata (bus.rx_data),
        .raddr (rptr),
        .rdata (head)
    );

    assign bus.rx_done = done_q;
    assign bus.count   = cnt;
    assign bus.empty   = (cnt == '0);
    assign bus.full    = (cnt == FULL_CNT);
    assign bus.ovr     = ovr_q;
    assign bus.rd_data = (cnt == '0) ? 8'h00 : head;
endmodule
